// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the I2C target peripheral.
package i2c_target_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StRxByte,
    StRxAck,
    StTxByte,
    StTxAck,
    StWaitStop
  } i2c_tgt_state_e;

  // Register select values for addr_i[3:2]
  localparam logic [1:0] I2C_TGT_CTRL = 2'h0;
  localparam logic [1:0] I2C_TGT_STAT = 2'h1;
  localparam logic [1:0] I2C_TGT_RXD  = 2'h2;
  localparam logic [1:0] I2C_TGT_TXD  = 2'h3;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/i2c_tgt_line_cond.sv
// I2C line conditioner: 2-FF sync of SCL/SDA, optional 3-sample majority filter
// (enabled by defining I2C_TGT_GLITCH_FILTER_EN), and SCL edge / START / STOP detection.
module i2c_tgt_line_cond (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_c, sda_c;
  logic       scl_prev_q, sda_prev_q;

  // Two-stage synchronisers; idle bus level is high
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
    end
  end

`ifdef I2C_TGT_GLITCH_FILTER_EN
  logic [1:0] scl_hist_q, sda_hist_q;
  logic       scl_filt_q, sda_filt_q;

  // Majority of the last three synced samples rejects single-cycle pulses
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scl_hist_q <= 2'b11;
      sda_hist_q <= 2'b11;
      scl_filt_q <= 1'b1;
      sda_filt_q <= 1'b1;
    end else begin
      scl_hist_q <= {scl_hist_q[0], scl_sync_q[1]};
      sda_hist_q <= {sda_hist_q[0], sda_sync_q[1]};
      scl_filt_q <= i2c_target_pkg::maj3(scl_sync_q[1], scl_hist_q[0], scl_hist_q[1]);
      sda_filt_q <= i2c_target_pkg::maj3(sda_sync_q[1], sda_hist_q[0], sda_hist_q[1]);
    end
  end

  assign scl_c = scl_filt_q;
  assign sda_c = sda_filt_q;
`else
  assign scl_c = scl_sync_q[1];
  assign sda_c = sda_sync_q[1];
`endif

  // Previous conditioned levels for edge detection
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_prev_q <= scl_c;
      sda_prev_q <= sda_c;
    end
  end

  assign scl_rise_o = scl_c & ~scl_prev_q;
  assign scl_fall_o = ~scl_c & scl_prev_q;
  // SDA may only move with SCL held high for START/STOP
  assign start_o    = scl_c & scl_prev_q & sda_prev_q & ~sda_c;
  assign stop_o     = scl_c & scl_prev_q & ~sda_prev_q & sda_c;
  assign sda_o      = sda_c;

endmodule

// File: rtl/i2c_target.sv
// I2C target (responder) on the RIB bus: 7-bit address match, RX/TX byte buffers, ACK/NACK,
// four word registers and a level interrupt. Optional input glitch filter: I2C_TGT_GLITCH_FILTER_EN.
module i2c_target
  import i2c_target_pkg::*;
#(
  parameter logic [6:0]  RESET_ADDR = 7'h42,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              ready_o,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              sda_o,
  output logic              sda_t_o,
  output logic              int_o
);

  logic sda, scl_rise, scl_fall, start, stop;

  i2c_tgt_line_cond u_line_cond (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .scl_i      (scl_i),
    .sda_i      (sda_i),
    .sda_o      (sda),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (start),
    .stop_o     (stop)
  );

  i2c_tgt_state_e    state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [7:0]        shift_q, shift_d, rx_data_q, rx_data_d, tx_buf_q, tx_buf_d, rx_byte;
  logic [6:0]        own_addr_q, own_addr_d;
  logic              sda_t_q, sda_t_d, ack_q, ack_d, tx_load;
  logic              rx_valid_q, rx_valid_d, overrun_q, overrun_d, underrun_q, underrun_d;
  logic              stop_seen_q, stop_seen_d, dir_q, dir_d, busy_q, busy_d, tx_full_q, tx_full_d;
  logic              en_q, en_d, rxie_q, rxie_d, stie_q, stie_d, ready_q;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              unused_bits;

  assign unused_bits = ^{addr_i, data_i};

  // Bus decode, line-side FSM and flag updates; hardware sets take priority over CPU clears
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    sda_t_d     = sda_t_q;
    ack_d       = ack_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    overrun_d   = overrun_q;
    underrun_d  = underrun_q;
    stop_seen_d = stop_seen_q;
    dir_d       = dir_q;
    busy_d      = busy_q;
    tx_full_d   = tx_full_q;
    tx_buf_d    = tx_buf_q;
    own_addr_d  = own_addr_q;
    en_d        = en_q;
    rxie_d      = rxie_q;
    stie_d      = stie_q;
    rdata_d     = '0;
    tx_load     = 1'b0;
    rx_byte     = {shift_q[6:0], sda};

    if (req_i) begin
      unique case (addr_i[3:2])
        I2C_TGT_CTRL: begin
          if (we_i) begin
            own_addr_d = data_i[14:8];
            stie_d     = data_i[2];
            rxie_d     = data_i[1];
            en_d       = data_i[0];
          end else begin
            rdata_d[14:8] = own_addr_q;
            rdata_d[2:0]  = {stie_q, rxie_q, en_q};
          end
        end
        I2C_TGT_STAT: begin
          if (we_i) begin
            if (data_i[6]) stop_seen_d = 1'b0;
            if (data_i[5]) overrun_d   = 1'b0;
            if (data_i[4]) underrun_d  = 1'b0;
          end else begin
            rdata_d[6:0] = {stop_seen_q, overrun_q, underrun_q, dir_q, busy_q, tx_full_q,
                            rx_valid_q};
          end
        end
        I2C_TGT_RXD: begin
          if (!we_i) begin
            rdata_d[7:0] = rx_data_q;
            rx_valid_d   = 1'b0;
          end
        end
        default: ;  // TXDATA write applied below, after any same-cycle shifter load
      endcase
    end

    if (!en_q) begin
      state_d = StIdle;
      sda_t_d = 1'b0;
      busy_d  = 1'b0;
    end else if (stop) begin
      state_d     = StIdle;
      sda_t_d     = 1'b0;
      busy_d      = 1'b0;
      stop_seen_d = 1'b1;
    end else if (start) begin
      state_d = StAddr;
      cnt_d   = 4'd0;
      sda_t_d = 1'b0;
    end else begin
      unique case (state_q)
        StAddr: begin
          if (scl_rise) begin
            shift_d = rx_byte;
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              if (shift_q[6:0] == own_addr_q) begin
                state_d = StAddrAck;
                dir_d   = sda;
                busy_d  = 1'b1;
                ack_d   = 1'b1;
              end else begin
                state_d = StWaitStop;
                busy_d  = 1'b0;
              end
            end
          end
        end
        // Ack phases: cnt=8 first fall drives the ack bit, 9th rise wraps to 0, next fall moves on
        StAddrAck, StRxAck: begin
          if (scl_fall && cnt_q == 4'd8) begin
            sda_t_d = ack_q;
          end else if (scl_rise) begin
            cnt_d = 4'd0;
          end else if (scl_fall && cnt_q == 4'd0) begin
            if (state_q == StAddrAck && dir_q) begin
              state_d = StTxByte;
              tx_load = 1'b1;
            end else begin
              state_d = StRxByte;
              sda_t_d = 1'b0;
            end
          end
        end
        StRxByte: begin
          if (scl_rise) begin
            shift_d = rx_byte;
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              state_d = StRxAck;
              if (!rx_valid_q) begin
                rx_data_d  = rx_byte;
                rx_valid_d = 1'b1;
                ack_d      = 1'b1;
              end else begin
                overrun_d = 1'b1;
                ack_d     = 1'b0;
              end
            end
          end
        end
        StTxByte: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              state_d = StTxAck;
              sda_t_d = 1'b0;
            end else begin
              shift_d = {shift_q[6:0], 1'b1};
              sda_t_d = ~shift_q[6];
            end
          end
        end
        StTxAck: begin
          if (scl_rise) begin
            if (sda) state_d = StWaitStop;
            else     cnt_d   = 4'd0;
          end else if (scl_fall && cnt_q == 4'd0) begin
            state_d = StTxByte;
            tx_load = 1'b1;
          end
        end
        default: ;  // StIdle, StWaitStop: only START/STOP matter
      endcase
    end

    if (tx_load) begin
      if (tx_full_q) begin
        shift_d   = tx_buf_q;
        tx_full_d = 1'b0;
      end else begin
        shift_d    = 8'hFF;
        underrun_d = 1'b1;
      end
      sda_t_d = ~shift_d[7];
    end

    if (req_i && we_i && addr_i[3:2] == I2C_TGT_TXD) begin
      tx_buf_d  = data_i[7:0];
      tx_full_d = 1'b1;
    end
  end

  // State and register storage
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      shift_q     <= 8'h00;
      sda_t_q     <= 1'b0;
      ack_q       <= 1'b0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      underrun_q  <= 1'b0;
      stop_seen_q <= 1'b0;
      dir_q       <= 1'b0;
      busy_q      <= 1'b0;
      tx_full_q   <= 1'b0;
      tx_buf_q    <= 8'h00;
      own_addr_q  <= RESET_ADDR;
      en_q        <= 1'b0;
      rxie_q      <= 1'b0;
      stie_q      <= 1'b0;
      ready_q     <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      sda_t_q     <= sda_t_d;
      ack_q       <= ack_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
      underrun_q  <= underrun_d;
      stop_seen_q <= stop_seen_d;
      dir_q       <= dir_d;
      busy_q      <= busy_d;
      tx_full_q   <= tx_full_d;
      tx_buf_q    <= tx_buf_d;
      own_addr_q  <= own_addr_d;
      en_q        <= en_d;
      rxie_q      <= rxie_d;
      stie_q      <= stie_d;
      ready_q     <= req_i;
      rdata_q     <= rdata_d;
    end
  end

  assign data_o  = rdata_q;
  assign ready_o = ready_q;
  assign sda_o   = 1'b0;
  assign sda_t_o = sda_t_q;
  assign int_o   = (rx_valid_q & rxie_q) | (stop_seen_q & stie_q);

endmodule

// File: tb/tb_i2c_target.sv
// Self-checking bench for i2c_target: drives an I2C master on the pads and the RIB bus,
// with expected bus read data, ack bits and read bytes queued in a scoreboard.
module tb_i2c_target;

  logic        clk = 1'b0, rst_n = 1'b0, req = 1'b0, we = 1'b0;
  logic [31:0] addr = '0, wdata = '0, rdata;
  logic        ready, scl_m = 1'b1, sda_m = 1'b1, sda_pad, sda_t, irq, sda_line;
  int          n_checks = 0, n_fail = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t exp_q[$];

  assign sda_line = sda_m & ~sda_t;  // open-drain wired-AND

  i2c_target dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .req_i   (req),
    .we_i    (we),
    .addr_i  (addr),
    .data_i  (wdata),
    .data_o  (rdata),
    .ready_o (ready),
    .scl_i   (scl_m),
    .sda_i   (sda_line),
    .sda_o   (sda_pad),
    .sda_t_o (sda_t),
    .int_o   (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic pop_cmp(input logic [31:0] obs);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_empty: got 0x%0h expected an entry", obs);
    end else begin
      e = exp_q.pop_front();
      check_eq(e.tag, obs, e.val);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    req = 1'b0; we = 1'b0;
  endtask

  task automatic bus_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
    push_exp(tag, exp);
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = a;
    @(negedge clk);
    req = 1'b0;
    check_eq({tag, "_ready"}, ready, 1);
    pop_cmp(rdata);
    @(negedge clk);
    check_eq({tag, "_ready_drop"}, ready, 0);
  endtask

  task automatic tq();
    repeat (10) @(negedge clk);
  endtask

  task automatic i2c_bit(input logic b, output logic r);
    sda_m = b;
    tq();
    scl_m = 1'b1;
    tq();
    r = sda_line;
    tq();
    scl_m = 1'b0;
    tq();
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; tq();
    scl_m = 1'b1; tq();
    sda_m = 1'b0; tq();
    scl_m = 1'b0; tq();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; tq();
    scl_m = 1'b1; tq();
    sda_m = 1'b1; tq();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) i2c_bit(b[i], r);
    i2c_bit(1'b1, r);
    ack = ~r;
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] b);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      i2c_bit(1'b1, r);
      b[i] = r;
    end
    i2c_bit(~mack, r);
  endtask

  task automatic send_w(input string tag, input logic [7:0] b, input logic exp_ack);
    logic ack;
    push_exp(tag, {31'b0, exp_ack});
    write_byte(b, ack);
    pop_cmp({31'b0, ack});
  endtask

  task automatic recv_r(input string tag, input logic mack, input logic [7:0] exp);
    logic [7:0] b;
    push_exp(tag, {24'b0, exp});
    read_byte(mack, b);
    pop_cmp({24'b0, b});
  endtask

  initial begin
    logic r;
    // Reset values
    repeat (3) @(negedge clk);
    check_eq("rst_ready", ready, 0);
    check_eq("rst_data", rdata, 0);
    check_eq("rst_sda_t", sda_t, 0);
    check_eq("rst_int", irq, 0);
    check_eq("rst_sda_o", sda_pad, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    bus_read("ctrl_rst", 32'h0, 32'h4200);
    bus_read("stat_rst", 32'h4, 32'h0);
    bus_write(32'h0, 32'h4203);

    // Single write byte, then STOP
    i2c_start();
    send_w("t1_addr_ack", 8'h84, 1'b1);
    send_w("t1_data_ack", 8'hA5, 1'b1);
    i2c_stop(); tq();
    bus_read("t1_status", 32'h4, 32'h41);
    check_eq("t1_int", irq, 1);
    bus_read("t1_rxdata", 32'h8, 32'hA5);
    bus_read("t1_status2", 32'h4, 32'h40);
    bus_write(32'h4, 32'h40);
    check_eq("t1_int_clr", irq, 0);

    // Foreign address: NACK and ignore until STOP
    i2c_start();
    send_w("t2_addr_nack", 8'h86, 1'b0);
    send_w("t2_data_nack", 8'h55, 1'b0);
    bus_read("t2_status", 32'h4, 32'h0);
    i2c_stop(); tq();
    bus_write(32'h4, 32'h70);

    // Overrun with STOP interrupt enabled
    bus_write(32'h0, 32'h4205);
    i2c_start();
    send_w("t3_addr_ack", 8'h84, 1'b1);
    send_w("t3_d0_ack", 8'h11, 1'b1);
    send_w("t3_d1_nack", 8'h22, 1'b0);
    i2c_stop(); tq();
    check_eq("t3_int_stop", irq, 1);
    bus_read("t3_status", 32'h4, 32'h61);
    bus_read("t3_rxdata", 32'h8, 32'h11);
    bus_write(32'h4, 32'h70);
    check_eq("t3_int_clr", irq, 0);
    bus_write(32'h0, 32'h4203);

    // Read transfer with underrun on the second byte
    bus_write(32'hC, 32'h3C);
    bus_read("t4_txfull", 32'h4, 32'h02);
    i2c_start();
    send_w("t4_addr_ack", 8'h85, 1'b1);
    recv_r("t4_rd0", 1'b1, 8'h3C);
    recv_r("t4_rd1", 1'b0, 8'hFF);
    i2c_stop(); tq();
    bus_read("t4_status", 32'h4, 32'h58);
    bus_write(32'h4, 32'h70);

    // Write then repeated START into a read, no STOP in between
    i2c_start();
    send_w("t5_waddr_ack", 8'h84, 1'b1);
    send_w("t5_wdata_ack", 8'h01, 1'b1);
    bus_read("t5_status_w", 32'h4, 32'h05);
    bus_write(32'hC, 32'h5A);
    i2c_start();
    send_w("t5_raddr_ack", 8'h85, 1'b1);
    bus_read("t5_status_r", 32'h4, 32'h0D);
    recv_r("t5_rd", 1'b0, 8'h5A);
    i2c_stop(); tq();
    bus_read("t5_status_end", 32'h4, 32'h49);
    bus_read("t5_rxdata", 32'h8, 32'h01);
    bus_write(32'h4, 32'h70);

    // EN cleared while driving the address ACK
    i2c_start();
    for (int i = 7; i >= 0; i--) i2c_bit(((8'h84 >> i) & 8'h1) != 0, r);
    check_eq("t6_ack_drive", sda_t, 1);
    bus_write(32'h0, 32'h4202);
    @(negedge clk);
    check_eq("t6_en_release", sda_t, 0);
    i2c_bit(1'b1, r);
    i2c_stop(); tq();
    bus_read("t6_status", 32'h4, 32'h0);

    // Reset asserted while driving the address ACK
    bus_write(32'h0, 32'h4203);
    i2c_start();
    for (int i = 7; i >= 0; i--) i2c_bit(((8'h84 >> i) & 8'h1) != 0, r);
    check_eq("t7_ack_drive", sda_t, 1);
    #2 rst_n = 1'b0;
    #1 check_eq("t7_rst_release", sda_t, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    i2c_bit(1'b1, r);
    i2c_stop(); tq();
    bus_read("t7_ctrl", 32'h0, 32'h4200);
    bus_read("t7_status", 32'h4, 32'h0);
    check_eq("t7_int", irq, 0);
    check_eq("sb_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
